// File: rtl/exception_controller_pkg.sv
// Shared constants and types for the exception controller.
// Optional per-source statistics counters are enabled by the EXC_COUNT_EN macro.
package global_exception;

  localparam int NO_CLASS     = 0;
  localparam int NO_EXCEPTION = 0;

  // Class codes of the pipeline sources; each equals its priority index + 1.
  localparam int CLS_CONTROL  = 1;
  localparam int CLS_REGISTER = 2;
  localparam int CLS_ALU      = 3;
  localparam int CLS_DMEM     = 4;
  localparam int CLS_IMEM     = 5;

  // Widths of the default five-source configuration.
  localparam int DEF_NUM_SOURCES = 5;
  localparam int DEF_CLASS_W     = $clog2(DEF_NUM_SOURCES + 1);
  localparam int DEF_CODE_W      = 2;
  localparam int DEF_ADDR_W      = 64;
  localparam int DEF_INSTR_W     = 64;

  typedef enum logic {
    IDLE   = 1'b0,
    REPORT = 1'b1
  } exc_state_t;

  // Report layout for the default configuration; the top declares a
  // width-parametrised struct with the same field order.
  typedef struct packed {
    logic [DEF_CLASS_W-1:0] cls;
    logic [DEF_CODE_W-1:0]  code;
    logic [DEF_ADDR_W-1:0]  address;
    logic [DEF_INSTR_W-1:0] instruction;
  } exc_report_t;

endpackage

// File: rtl/exception_controller_if.sv
// Bus between the pipeline/trap logic and the exception controller.
// countClear/excCount (and CNT_W) exist only when EXC_COUNT_EN is defined.
interface exception_controller_if #(
  parameter int NUM_SOURCES = 5,
  parameter int CODE_W      = 2,
  parameter int ADDR_W      = 64,
  parameter int INSTR_W     = 64
`ifdef EXC_COUNT_EN
  ,
  parameter int CNT_W       = 16
`endif
);
  localparam int CLASS_W = $clog2(NUM_SOURCES + 1);

  logic [NUM_SOURCES*CODE_W-1:0] excIn;
  logic [NUM_SOURCES-1:0]        excMask;
  logic [ADDR_W-1:0]             instructionAddress;
  logic [INSTR_W-1:0]            instruction;
  logic                          excAck;
  logic                          excValid;
  logic [CLASS_W+CODE_W-1:0]     exception;
  logic [ADDR_W-1:0]             badAddress;
  logic [INSTR_W-1:0]            badInstruction;
  logic                          excLost;
  logic                          pipeStall;
`ifdef EXC_COUNT_EN
  logic                          countClear;
  logic [NUM_SOURCES*CNT_W-1:0]  excCount;
`endif

  // Pipeline/trap side.
  modport master (
    output excIn, excMask, instructionAddress, instruction, excAck,
`ifdef EXC_COUNT_EN
    output countClear,
    input  excCount,
`endif
    input  excValid, exception, badAddress, badInstruction, excLost, pipeStall
  );

  // Controller side.
  modport slave (
    input  excIn, excMask, instructionAddress, instruction, excAck,
`ifdef EXC_COUNT_EN
    input  countClear,
    output excCount,
`endif
    output excValid, exception, badAddress, badInstruction, excLost, pipeStall
  );

endinterface

// File: rtl/exception_controller_priority_encoder.sv
// Fixed-priority pick among unmasked, nonzero exception codes; index 0 wins.
module exception_priority_encoder #(
  parameter int NUM_SOURCES = 5,
  parameter int CODE_W      = 2,
  parameter int IDX_W       = 3
) (
  input  logic [NUM_SOURCES*CODE_W-1:0] exc_in_i,
  input  logic [NUM_SOURCES-1:0]        exc_mask_i,
  output logic                          any_active_o,
  output logic [IDX_W-1:0]              win_idx_o,
  output logic [CODE_W-1:0]             win_code_o
);

  // Scan from lowest priority upwards so the lowest active index lands last.
  always_comb begin
    any_active_o = 1'b0;
    win_idx_o    = '0;
    win_code_o   = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if ((exc_in_i[i*CODE_W +: CODE_W] != '0) && !exc_mask_i[i]) begin
        any_active_o = 1'b1;
        win_idx_o    = IDX_W'(i);
        win_code_o   = exc_in_i[i*CODE_W +: CODE_W];
      end
    end
  end

endmodule

// File: rtl/exception_controller.sv
// Registered exception controller: priority select, latch report, hold it
// under a valid/ack handshake and stall the pipeline while it is held.
// Optional feature macro: EXC_COUNT_EN (saturating per-source capture counters).
module exception_controller
  import global_exception::*;
#(
  parameter int NUM_SOURCES = 5,
  parameter int CODE_W      = 2,
  parameter int ADDR_W      = 64,
  parameter int INSTR_W     = 64
`ifdef EXC_COUNT_EN
  ,
  parameter int CNT_W       = 16
`endif
) (
  input logic                    clk,
  input logic                    resetN,
  exception_controller_if.slave  bus
);

  localparam int CLASS_W = $clog2(NUM_SOURCES + 1);

  typedef struct packed {
    logic [CLASS_W-1:0] cls;
    logic [CODE_W-1:0]  code;
    logic [ADDR_W-1:0]  address;
    logic [INSTR_W-1:0] instruction;
  } rpt_t;

  logic               any_active;
  logic [CLASS_W-1:0] win_idx;
  logic [CODE_W-1:0]  win_code;

  exc_state_t state_q;
  rpt_t       rpt_q;
  rpt_t       cap_d;
  logic       valid_q;
  logic       lost_q;
  logic       capture;

  exception_priority_encoder #(
    .NUM_SOURCES (NUM_SOURCES),
    .CODE_W      (CODE_W),
    .IDX_W       (CLASS_W)
  ) u_prio (
    .exc_in_i     (bus.excIn),
    .exc_mask_i   (bus.excMask),
    .any_active_o (any_active),
    .win_idx_o    (win_idx),
    .win_code_o   (win_code)
  );

  // Candidate report built from the current winner and faulting stage.
  always_comb begin
    cap_d             = '0;
    cap_d.cls         = win_idx + CLASS_W'(1);
    cap_d.code        = win_code;
    cap_d.address     = bus.instructionAddress;
    cap_d.instruction = bus.instruction;
  end

  // A capture happens from IDLE, or back-to-back when the held report is acked.
  assign capture = any_active && ((state_q == IDLE) || bus.excAck);

  // Report FSM; every output is a register so nothing flows combinationally
  // from the inputs to the trap logic.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      rpt_q   <= '0;
      valid_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_active) begin
            rpt_q   <= cap_d;
            valid_q <= 1'b1;
            state_q <= REPORT;
          end
        end
        REPORT: begin
          if (bus.excAck) begin
            lost_q <= 1'b0;
            if (any_active) begin
              rpt_q <= cap_d;
            end else begin
              rpt_q   <= '0;
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end else if (any_active) begin
            // Held report wins; the newcomer is dropped and flagged.
            lost_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          rpt_q   <= '0;
          valid_q <= 1'b0;
          lost_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.excValid       = valid_q;
  assign bus.pipeStall      = valid_q;
  assign bus.exception      = {rpt_q.cls, rpt_q.code};
  assign bus.badAddress     = rpt_q.address;
  assign bus.badInstruction = rpt_q.instruction;
  assign bus.excLost        = lost_q;

`ifdef EXC_COUNT_EN
  logic [NUM_SOURCES-1:0][CNT_W-1:0] cnt_q;

  // Saturating per-source capture counters; clear beats increment.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        if (bus.countClear) begin
          cnt_q[i] <= '0;
        end else if (capture && (win_idx == CLASS_W'(i)) && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign bus.excCount = cnt_q;
`endif

endmodule

// File: tb/tb_exception_controller.sv
// Bench for exception_controller: directed vector table, hand-written
// reset/counter sequences and a randomized run against a reference model.
module tb_exception_controller;

  localparam int NS = 5;
  localparam int CW = 2;
  localparam int AW = 64;
  localparam int IW = 64;
  localparam int CNTW = 2;

  logic clk;
  logic resetN;
  int   n_cmp = 0;
  int   n_err = 0;

  exception_controller_if #(
    .NUM_SOURCES(NS), .CODE_W(CW), .ADDR_W(AW), .INSTR_W(IW)
`ifdef EXC_COUNT_EN
    , .CNT_W(CNTW)
`endif
  ) bus ();

  exception_controller #(
    .NUM_SOURCES(NS), .CODE_W(CW), .ADDR_W(AW), .INSTR_W(IW)
`ifdef EXC_COUNT_EN
    , .CNT_W(CNTW)
`endif
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NS*CW-1:0] exc;
    logic [NS-1:0]    mask;
    logic [AW-1:0]    addr;
    logic [IW-1:0]    instr;
    logic             ack;
    logic             e_valid;
    logic [4:0]       e_exc;
    logic [AW-1:0]    e_addr;
    logic [IW-1:0]    e_instr;
    logic             e_lost;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [NS*CW-1:0] exc, input logic [NS-1:0] mask,
                              input logic [AW-1:0] addr, input logic [IW-1:0] instr,
                              input logic ack, input logic ev, input logic [4:0] ee,
                              input logic [AW-1:0] ea, input logic [IW-1:0] ei,
                              input logic el);
    vec_t v;
    v.exc = exc; v.mask = mask; v.addr = addr; v.instr = instr; v.ack = ack;
    v.e_valid = ev; v.e_exc = ee; v.e_addr = ea; v.e_instr = ei; v.e_lost = el;
    return v;
  endfunction

  function automatic logic [4:0] ex(input int cls, input int code);
    logic [2:0] c3;
    logic [1:0] c2;
    c3 = 3'(cls);
    c2 = 2'(code);
    return {c3, c2};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NS*CW-1:0] exc, input logic [NS-1:0] mask,
                       input logic [AW-1:0] addr, input logic [IW-1:0] instr,
                       input logic ack);
    bus.excIn = exc;
    bus.excMask = mask;
    bus.instructionAddress = addr;
    bus.instruction = instr;
    bus.excAck = ack;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [4:0] e,
                         input logic [63:0] a, input logic [63:0] i, input logic l);
    chk({tag, ".valid"}, 64'(bus.excValid), 64'(v));
    chk({tag, ".stall"}, 64'(bus.pipeStall), 64'(v));
    chk({tag, ".exc"}, 64'(bus.exception), 64'(e));
    chk({tag, ".addr"}, bus.badAddress, a);
    chk({tag, ".instr"}, bus.badInstruction, i);
    chk({tag, ".lost"}, 64'(bus.excLost), 64'(l));
  endtask

  // Reference model state: plain variables describing the held report.
  bit          m_held;
  logic [4:0]  m_exc;
  logic [63:0] m_addr, m_instr;
  bit          m_lost;
  int          m_cnt[NS];

  initial begin
    string nm;
    resetN = 1'b0;
    drive('0, '0, '0, '0, 1'b0);
`ifdef EXC_COUNT_EN
    bus.countClear = 1'b0;
`endif
    #12;
    chk_out("reset", 1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
`ifdef EXC_COUNT_EN
    chk("reset.count", 64'(bus.excCount), 64'd0);
`endif
    resetN = 1'b1;
    tick();

    // ---------------- directed vector table ----------------
    vt.push_back(mk(10'h010, 5'h00, 64'h1000, 64'h13, 1'b0, 1'b1, ex(3,1), 64'h1000, 64'h13, 1'b0));
    vt.push_back(mk(10'h000, 5'h00, 64'h0,    64'h0,  1'b1, 1'b0, ex(0,0), 64'h0,    64'h0,  1'b0));
    vt.push_back(mk(10'h048, 5'h00, 64'h10,   64'h20, 1'b0, 1'b1, ex(2,2), 64'h10,   64'h20, 1'b0));
    vt.push_back(mk(10'h000, 5'h00, 64'h0,    64'h0,  1'b1, 1'b0, ex(0,0), 64'h0,    64'h0,  1'b0));
    vt.push_back(mk(10'h048, 5'h02, 64'h30,   64'h40, 1'b0, 1'b1, ex(4,1), 64'h30,   64'h40, 1'b0));
    vt.push_back(mk(10'h000, 5'h00, 64'h0,    64'h0,  1'b1, 1'b0, ex(0,0), 64'h0,    64'h0,  1'b0));
    vt.push_back(mk(10'h3FF, 5'h1F, 64'h44,   64'h55, 1'b0, 1'b0, ex(0,0), 64'h0,    64'h0,  1'b0));
    vt.push_back(mk(10'h002, 5'h00, 64'h50,   64'h60, 1'b0, 1'b1, ex(1,2), 64'h50,   64'h60, 1'b0));
    // masked source while reporting: no loss, report unchanged
    vt.push_back(mk(10'h003, 5'h01, 64'h77,   64'h88, 1'b0, 1'b1, ex(1,2), 64'h50,   64'h60, 1'b0));
    // unmasked newcomer without ack: lost, report unchanged
    vt.push_back(mk(10'h001, 5'h00, 64'h99,   64'hAA, 1'b0, 1'b1, ex(1,2), 64'h50,   64'h60, 1'b1));
    // mask change while reporting: report still held
    vt.push_back(mk(10'h000, 5'h1F, 64'h0,    64'h0,  1'b0, 1'b1, ex(1,2), 64'h50,   64'h60, 1'b1));
    // back-to-back capture clears lost
    vt.push_back(mk(10'h300, 5'h00, 64'h2000, 64'h77, 1'b1, 1'b1, ex(5,3), 64'h2000, 64'h77, 1'b0));
    vt.push_back(mk(10'h000, 5'h00, 64'h0,    64'h0,  1'b1, 1'b0, ex(0,0), 64'h0,    64'h0,  1'b0));
    // ack in IDLE does nothing
    vt.push_back(mk(10'h000, 5'h00, 64'h5,    64'h6,  1'b1, 1'b0, ex(0,0), 64'h0,    64'h0,  1'b0));

    for (int k = 0; k < vt.size(); k++) begin
      drive(vt[k].exc, vt[k].mask, vt[k].addr, vt[k].instr, vt[k].ack);
      tick();
      nm = $sformatf("vec%0d", k);
      chk_out(nm, vt[k].e_valid, vt[k].e_exc, vt[k].e_addr, vt[k].e_instr, vt[k].e_lost);
    end

    // ---------------- reset mid-report ----------------
    drive(10'h080, 5'h00, 64'h3000, 64'h33, 1'b0);
    tick();
    chk_out("rst_pre", 1'b1, ex(4,2), 64'h3000, 64'h33, 1'b0);
    drive('0, '0, '0, '0, 1'b0);
    #2 resetN = 1'b0;
    #1 chk_out("rst_mid", 1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
    #2 resetN = 1'b1;
    bus.excAck = 1'b1;
    tick();
    chk_out("rst_ack", 1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
    bus.excAck = 1'b0;

`ifdef EXC_COUNT_EN
    // ---------------- counters ----------------
    resetN = 1'b0;
    #2 resetN = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(10'h001, 5'h00, 64'h10, 64'h20, 1'b0);
      tick();
      drive('0, '0, '0, '0, 1'b1);
      tick();
    end
    chk("cnt_sat", 64'(bus.excCount[CNTW-1:0]), 64'd3);
    drive(10'h001, 5'h00, 64'h10, 64'h20, 1'b0);
    bus.countClear = 1'b1;
    tick();
    bus.countClear = 1'b0;
    chk("cnt_clr", 64'(bus.excCount[CNTW-1:0]), 64'd0);
    chk("cnt_clr.valid", 64'(bus.excValid), 64'd1);
    drive('0, '0, '0, '0, 1'b1);
    tick();
`endif

    // ---------------- randomized run vs reference model ----------------
    resetN = 1'b0;
    drive('0, '0, '0, '0, 1'b0);
    #2 resetN = 1'b1;
    m_held = 0; m_exc = '0; m_addr = '0; m_instr = '0; m_lost = 0;
    for (int s = 0; s < NS; s++) m_cnt[s] = 0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [NS*CW-1:0] r_exc;
      logic [NS-1:0]    r_mask;
      logic [63:0]      r_addr, r_instr;
      logic             r_ack, r_clr;
      int               w;
      r_exc = '0;
      r_mask = '0;
      for (int s = 0; s < NS; s++) begin
        if ($urandom_range(0, 4) == 0) r_exc[s*CW +: CW] = CW'($urandom_range(1, 3));
        if ($urandom_range(0, 3) == 0) r_mask[s] = 1'b1;
      end
      r_addr  = {$urandom, $urandom};
      r_instr = {$urandom, $urandom};
      r_ack   = 1'($urandom_range(0, 1));
      r_clr   = ($urandom_range(0, 15) == 0);
      drive(r_exc, r_mask, r_addr, r_instr, r_ack);
`ifdef EXC_COUNT_EN
      bus.countClear = r_clr;
`endif

      // winner: first unmasked source with a nonzero code
      w = -1;
      for (int s = 0; s < NS; s++)
        if (w < 0 && r_exc[s*CW +: CW] != 0 && !r_mask[s]) w = s;

      if (!m_held || r_ack) begin
        if (w >= 0) begin
          m_held = 1; m_exc = ex(w + 1, int'(r_exc[w*CW +: CW]));
          m_addr = r_addr; m_instr = r_instr; m_lost = 0;
          if (!r_clr && m_cnt[w] < (1 << CNTW) - 1) m_cnt[w]++;
        end else if (m_held) begin
          m_held = 0; m_exc = '0; m_addr = '0; m_instr = '0; m_lost = 0;
        end
      end else if (w >= 0) begin
        m_lost = 1;
      end
      if (r_clr)
        for (int s = 0; s < NS; s++) m_cnt[s] = 0;

      tick();
      chk_out("rnd", m_held, m_exc, m_addr, m_instr, m_lost);
`ifdef EXC_COUNT_EN
      for (int s = 0; s < NS; s++)
        chk("rnd.cnt", 64'(bus.excCount[s*CNTW +: CNTW]), 64'(m_cnt[s]));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
